tss_cmd_host_slave: RTL and testbench
=====================================

# tss_cmd_host_slave

Parametrised multi-channel host register slave for the TSS controller. Host software configures per-channel transmit parameters over a Wishbone-style slave port. Writes to a channel's CONTROL register build a timestamped command and queue it in a per-channel command FIFO. Each FIFO drains to its TSS TX engine over a valid/ready handshake.

## Interface
- CHANNELS, 2: number of independent command channels (1..8)
- TS_W, 64: timestamp width
- FIFO_DEPTH, 4: commands queued per channel; power of two, ≥2
- DELTA_DEFAULT, 1000: default scheduling delta, readable at DELTA_TIME
- CMD_W, 200+TS_W: command width {last_frame, batch_interval, sequence_length, batch_length, frame_length, slice_length (32 b each), exec_time (TS_W), opcode (8)}
- clk  in  1  system clock, all logic on rising edge
- arst_n  in  1  asynchronous active-low reset
- wbs_stb_i  in  1  bus strobe
- wbs_we_i  in  1  1 = write, 0 = read
- wbs_addr_i  in  32  byte address
- wbs_data_i  in  32  write data
- wbs_data_o  out  32  read data, valid with ack
- wbs_ack_o  out  1  one-cycle acknowledge
- timer_valid_i  in  1  timer synchronised/valid
- timer_i  in  TS_W  current time
- cmd_valid_o  out  CHANNELS  FIFO head valid, one bit per channel
- cmd_data_o  out  CHANNELS*CMD_W  FIFO head; channel c at [c*CMD_W +: CMD_W]
- cmd_ready_i  in  CHANNELS  TX engine accepts head

## Operation
- Address map: channel c = addr[8:6], offset = addr[5:0]. Offsets: 0x00 SLICE_LENGTH, 0x04 FRAME_LENGTH, 0x08 BATCH_LENGTH, 0x0C SEQUENCE_LENGTH, 0x10 BATCH_INTERVAL, 0x14 LAST_FRAME, 0x18 DELTA_TIME (RO), 0x1C USER_DELTA_TIME, 0x20 CONTROL (WO, reads 0), 0x24 STATUS.
- Register reset values: config registers 0. DELTA_TIME reads DELTA_DEFAULT.
- Unmapped offset, channel ≥ CHANNELS, or addr[31:9]≠0: read returns 0, write ignored. Ack is still given.
- STATUS (per channel):
  - [0] overflow, sticky
  - [1] bad_code, sticky
  - [2] rejected, sticky
  - [3] full
  - [4] empty
  - [15:8] level
  - Writing 1 to any of [2:0] clears that bit; other STATUS write bits are ignored.
- CONTROL write, low 8 bits of data:
  - 0x01 START: all six fields; exec_time = timer_i + delta.
  - 0x02 STOP / 0x04 CONTINUE: fields 0; exec_time = timer_i + delta.
  - 0x08 ABORT: flush the channel FIFO, then enqueue {fields 0, exec_time 0, 0x08}.
  - delta = USER_DELTA_TIME if nonzero, else DELTA_DEFAULT, zero-extended to TS_W.
  - The sum wraps modulo 2^TS_W.
  - Any other code: nothing enqueued; bad_code is set.
- CONTROL write while timer_valid_i=0: nothing enqueued; rejected is set.
- CONTROL write when FIFO full, non-ABORT, no same-cycle pop: command dropped; overflow is set.
- Full FIFO with a pop in the same cycle: push accepted, level unchanged, no overflow.
- timer_valid_i low: all FIFOs flushed every cycle; cmd_valid_o = 0. Config registers and STATUS sticky bits are retained.
- ABORT on a full FIFO never overflows.
- Handshake completing on the same edge as an ABORT flush counts as delivered. All other entries are discarded.
- cmd_data_o is 0 whenever the corresponding cmd_valid_o is 0.
- Head stays stable while valid and not ready.

## Timing
- Reset (arst_n low, asynchronous) clears:
  - outputs: wbs_ack_o, wbs_data_o, cmd_valid_o, cmd_data_o all 0
  - all FIFOs, registers and STATUS bits
- A transaction executes on the edge where ack rises (stb=1, ack=0).
  - wbs_ack_o is high for exactly one cycle, then low for at least one cycle.
  - A held stb therefore yields ack every other cycle, one access per ack.
- Read data is registered on the ack edge and holds until the next read.
- CONTROL write: entry pushed on the ack edge. With an empty FIFO, cmd_valid_o is high in the same cycle as ack (first-word fall-through).
- exec_time samples timer_i on the ack edge.
- Pop occurs on any edge with cmd_valid_o & cmd_ready_i. The next entry is presented in the following cycle; throughput is one command per cycle per channel.
- Register writes take effect on the ack edge. A CONTROL write on a later access uses the updated values.

## Test plan
- Reset defaults:
  - Stimulus: reset, then read each offset of ch0/ch1.
  - Required: all 0 except DELTA_TIME=1000 and STATUS=0x0010.
  - cmd_valid_o=0, ack returns 1 cycle after stb.
- START with default delta:
  - Stimulus: timer_valid=1, timer=5000, slice=16, frame=64, write CONTROL=0x01 on ch1, ready low.
  - Required: cmd_valid_o=2'b10 in the ack cycle.
  - ch1 head = {0,0,0,0,64,16,6000,0x01}; the head holds until ready, then cmd_valid_o[1] falls next cycle.
- Wrap and user delta:
  - Stimulus: USER_DELTA=0x20, timer=2^64-0x10, STOP.
  - Required: exec_time=0x10, opcode 0x02.
- Overflow then ABORT:
  - Stimulus: ready=0, five STARTs on ch0 with depth 4.
  - Required: level=4 and overflow=1.
  - Then ABORT: level=1, head opcode 0x08 with exec_time 0.
  - Then write STATUS=1: overflow clears.
- Error paths:
  - Bad code: CONTROL=0x03 -> bad_code=1, level 0.
  - Timer invalid: timer_valid=0 with a queued command -> cmd_valid_o drops next edge. A CONTROL write then sets rejected; the config read-back is unchanged.
- Full with simultaneous pop:
  - Stimulus: FIFO full, cmd_ready_i=1 on the CONTROL ack edge.
  - Required: level stays 4, overflow=0, and the new entry appears last in order.

Source files
------------

// File: rtl/tss_cmd_host_slave_if.sv
// Host bus, timer and per-channel command stream bundle for tss_cmd_host_slave.
// The slave modport is the register block's view; the master modport is the host/TX-engine view.
interface tss_cmd_host_slave_if #(
   parameter int CHANNELS = 2,
   parameter int TS_W     = 64
);
   localparam int CMD_W = 200 + TS_W;

   logic                      wbs_stb_i;
   logic                      wbs_we_i;
   logic [31:0]               wbs_addr_i;
   logic [31:0]               wbs_data_i;
   logic [31:0]               wbs_data_o;
   logic                      wbs_ack_o;
   logic                      timer_valid_i;
   logic [TS_W-1:0]           timer_i;
   logic [CHANNELS-1:0]       cmd_valid_o;
   logic [CHANNELS*CMD_W-1:0] cmd_data_o;
   logic [CHANNELS-1:0]       cmd_ready_i;

   modport slave (
      input  wbs_stb_i, wbs_we_i, wbs_addr_i, wbs_data_i, timer_valid_i, timer_i, cmd_ready_i,
      output wbs_data_o, wbs_ack_o, cmd_valid_o, cmd_data_o
   );

   modport master (
      output wbs_stb_i, wbs_we_i, wbs_addr_i, wbs_data_i, timer_valid_i, timer_i, cmd_ready_i,
      input  wbs_data_o, wbs_ack_o, cmd_valid_o, cmd_data_o
   );
endinterface

// File: rtl/tss_cmd_host_slave.sv
// Per-channel config registers; CONTROL writes push timestamped commands into FWFT FIFOs.
// Ack one cycle after strobe; head visible in the ack cycle; a full FIFO drops pushes unless popped that edge.
module tss_cmd_host_slave #(
   parameter int CHANNELS      = 2,
   parameter int TS_W          = 64,
   parameter int FIFO_DEPTH    = 4,
   parameter int DELTA_DEFAULT = 1000
) (
   input logic                 clk,
   input logic                 arst_n,
   tss_cmd_host_slave_if.slave bus
);
   localparam int CMD_W = 200 + TS_W;
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int CW    = PW + 1;

   typedef struct packed {
      logic [31:0]     last_frame;
      logic [31:0]     batch_interval;
      logic [31:0]     sequence_length;
      logic [31:0]     batch_length;
      logic [31:0]     frame_length;
      logic [31:0]     slice_length;
      logic [TS_W-1:0] exec_time;
      logic [7:0]      opcode;
   } cmd_t;

   logic          ack_q, ack_d;
   logic [31:0]   rdata_q, rdata_d;
   // cfg index order: slice, frame, batch, sequence, interval, last_frame
   logic [31:0]   cfg_q    [CHANNELS][6];
   logic [31:0]   cfg_d    [CHANNELS][6];
   logic [31:0]   udelta_q [CHANNELS];
   logic [31:0]   udelta_d [CHANNELS];
   logic [2:0]    sticky_q [CHANNELS];
   logic [2:0]    sticky_d [CHANNELS];
   cmd_t          mem_q    [CHANNELS][FIFO_DEPTH];
   cmd_t          mem_d    [CHANNELS][FIFO_DEPTH];
   logic [PW-1:0] rptr_q   [CHANNELS];
   logic [PW-1:0] rptr_d   [CHANNELS];
   logic [PW-1:0] wptr_q   [CHANNELS];
   logic [PW-1:0] wptr_d   [CHANNELS];
   logic [CW-1:0] cnt_q    [CHANNELS];
   logic [CW-1:0] cnt_d    [CHANNELS];

   logic          txn, addr_ok;
   logic [2:0]    ch_sel;
   logic [5:0]    off;
   logic [7:0]    code;
   logic [CHANNELS-1:0] cmd_vld, wr_sel, ctrl_wr, pop, push;
   logic [31:0]   status [CHANNELS];
   logic [31:0]   delta  [CHANNELS];
   cmd_t          new_cmd [CHANNELS];

   assign txn     = bus.wbs_stb_i & ~ack_q;
   assign ch_sel  = bus.wbs_addr_i[8:6];
   assign off     = bus.wbs_addr_i[5:0];
   assign code    = bus.wbs_data_i[7:0];
   assign addr_ok = (bus.wbs_addr_i[31:9] == '0) && ({29'b0, ch_sel} < 32'(CHANNELS));

   assign bus.wbs_ack_o  = ack_q;
   assign bus.wbs_data_o = rdata_q;

   always_comb begin
      bus.cmd_valid_o = '0;
      bus.cmd_data_o  = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         cmd_vld[c] = (cnt_q[c] != '0);
         status[c]  = {16'b0, 8'(cnt_q[c]), 3'b0, cnt_q[c] == '0,
                       cnt_q[c] == CW'(FIFO_DEPTH), sticky_q[c]};
         bus.cmd_valid_o[c] = cmd_vld[c];
         bus.cmd_data_o[c*CMD_W +: CMD_W] = cmd_vld[c] ? mem_q[c][rptr_q[c]] : '0;
      end
   end

   always_comb begin
      ack_d    = txn;
      rdata_d  = rdata_q;
      cfg_d    = cfg_q;
      udelta_d = udelta_q;
      sticky_d = sticky_q;
      mem_d    = mem_q;
      rptr_d   = rptr_q;
      wptr_d   = wptr_q;
      cnt_d    = cnt_q;

      if (txn && !bus.wbs_we_i) begin
         rdata_d = '0;
         for (int c = 0; c < CHANNELS; c++) begin
            if (addr_ok && ch_sel == 3'(c)) begin
               case (off)
                  6'h00:   rdata_d = cfg_q[c][0];
                  6'h04:   rdata_d = cfg_q[c][1];
                  6'h08:   rdata_d = cfg_q[c][2];
                  6'h0C:   rdata_d = cfg_q[c][3];
                  6'h10:   rdata_d = cfg_q[c][4];
                  6'h14:   rdata_d = cfg_q[c][5];
                  6'h18:   rdata_d = 32'(DELTA_DEFAULT);
                  6'h1C:   rdata_d = udelta_q[c];
                  6'h24:   rdata_d = status[c];
                  default: rdata_d = '0;
               endcase
            end
         end
      end

      for (int c = 0; c < CHANNELS; c++) begin
         wr_sel[c]  = txn && bus.wbs_we_i && addr_ok && (ch_sel == 3'(c));
         ctrl_wr[c] = wr_sel[c] && (off == 6'h20);
         pop[c]     = cmd_vld[c] && bus.cmd_ready_i[c];
         push[c]    = 1'b0;
         delta[c]   = (udelta_q[c] != '0) ? udelta_q[c] : 32'(DELTA_DEFAULT);

         new_cmd[c]           = '0;
         new_cmd[c].opcode    = code;
         new_cmd[c].exec_time = bus.timer_i + TS_W'(delta[c]);
         if (code == 8'h01) begin
            new_cmd[c].slice_length    = cfg_q[c][0];
            new_cmd[c].frame_length    = cfg_q[c][1];
            new_cmd[c].batch_length    = cfg_q[c][2];
            new_cmd[c].sequence_length = cfg_q[c][3];
            new_cmd[c].batch_interval  = cfg_q[c][4];
            new_cmd[c].last_frame      = cfg_q[c][5];
         end

         if (wr_sel[c]) begin
            case (off)
               6'h00:   cfg_d[c][0] = bus.wbs_data_i;
               6'h04:   cfg_d[c][1] = bus.wbs_data_i;
               6'h08:   cfg_d[c][2] = bus.wbs_data_i;
               6'h0C:   cfg_d[c][3] = bus.wbs_data_i;
               6'h10:   cfg_d[c][4] = bus.wbs_data_i;
               6'h14:   cfg_d[c][5] = bus.wbs_data_i;
               6'h1C:   udelta_d[c] = bus.wbs_data_i;
               6'h24:   sticky_d[c] = sticky_q[c] & ~bus.wbs_data_i[2:0];
               default: ;
            endcase
         end

         if (!bus.timer_valid_i) begin
            rptr_d[c] = '0;
            wptr_d[c] = '0;
            cnt_d[c]  = '0;
            if (ctrl_wr[c]) sticky_d[c][2] = 1'b1;
         end else if (ctrl_wr[c] && code == 8'h08) begin
            // ABORT restarts the FIFO holding only the abort marker
            mem_d[c][0] = '{opcode: 8'h08, default: '0};
            rptr_d[c]   = '0;
            wptr_d[c]   = PW'(1);
            cnt_d[c]    = CW'(1);
         end else begin
            if (ctrl_wr[c]) begin
               if (code == 8'h01 || code == 8'h02 || code == 8'h04) begin
                  if (cnt_q[c] != CW'(FIFO_DEPTH) || pop[c]) push[c] = 1'b1;
                  else                                       sticky_d[c][0] = 1'b1;
               end else begin
                  sticky_d[c][1] = 1'b1;
               end
            end
            if (push[c]) begin
               mem_d[c][wptr_q[c]] = new_cmd[c];
               wptr_d[c]           = wptr_q[c] + PW'(1);
            end
            if (pop[c]) rptr_d[c] = rptr_q[c] + PW'(1);
            cnt_d[c] = cnt_q[c] + CW'(push[c]) - CW'(pop[c]);
         end
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         ack_q   <= 1'b0;
         rdata_q <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            for (int k = 0; k < 6; k++) cfg_q[c][k] <= '0;
            for (int d = 0; d < FIFO_DEPTH; d++) mem_q[c][d] <= '0;
            udelta_q[c] <= '0;
            sticky_q[c] <= '0;
            rptr_q[c]   <= '0;
            wptr_q[c]   <= '0;
            cnt_q[c]    <= '0;
         end
      end else begin
         ack_q    <= ack_d;
         rdata_q  <= rdata_d;
         cfg_q    <= cfg_d;
         udelta_q <= udelta_d;
         sticky_q <= sticky_d;
         mem_q    <= mem_d;
         rptr_q   <= rptr_d;
         wptr_q   <= wptr_d;
         cnt_q    <= cnt_d;
      end
   end
endmodule

// File: tb/tb_tss_cmd_host_slave.sv
// Directed bench for tss_cmd_host_slave: register table plus hand-written FIFO sequences.
module tb_tss_cmd_host_slave;
   localparam int CMD_W = 264;

   logic clk = 1'b0;
   logic arst_n = 1'b0;
   always #5 clk = ~clk;

   tss_cmd_host_slave_if #(.CHANNELS(2), .TS_W(64)) bus();

   tss_cmd_host_slave #(
      .CHANNELS(2), .TS_W(64), .FIFO_DEPTH(4), .DELTA_DEFAULT(1000)
   ) dut (
      .clk(clk),
      .arst_n(arst_n),
      .bus(bus)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      logic        chk;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vq[$];
   int   n_pass = 0;
   int   n_total = 0;
   logic [31:0] rd;

   task automatic chk(input string name, input logic [CMD_W-1:0] act, input logic [CMD_W-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [CMD_W-1:0] mk(input logic [31:0] frame, input logic [31:0] slice,
                                           input logic [63:0] exec, input logic [7:0] op);
      return {128'b0, frame, slice, exec, op};
   endfunction

   function automatic logic [CMD_W-1:0] head(input int c);
      return bus.cmd_data_o[c*CMD_W +: CMD_W];
   endfunction

   task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         output logic [31:0] rdat);
      int n = 0;
      bus.wbs_stb_i  = 1'b1;
      bus.wbs_we_i   = we;
      bus.wbs_addr_i = addr;
      bus.wbs_data_i = data;
      @(posedge clk); #1;
      while (!bus.wbs_ack_o && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.wbs_ack_o) begin
         n_total++;
         $display("FAIL ack_timeout: addr %h no ack within 10 cycles", addr);
      end
      rdat = bus.wbs_data_o;
      bus.wbs_stb_i = 1'b0;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      logic [31:0] dummy;
      access(1'b1, addr, data, dummy);
   endtask

   task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] r;
      access(1'b0, addr, 32'h0, r);
      chk(name, CMD_W'(r), CMD_W'(exp));
   endtask

   task automatic add(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic c, input logic [31:0] e, input string nm);
      vec_t v;
      v.we = we; v.addr = a; v.data = d; v.chk = c; v.exp = e; v.name = nm;
      vq.push_back(v);
   endtask

   initial begin
      logic [5:0] offs [10];
      offs = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h18, 6'h1C, 6'h20, 6'h24};

      for (int c = 0; c < 2; c++) begin
         for (int k = 0; k < 10; k++) begin
            add(1'b0, 32'(c * 64) + 32'(offs[k]), 32'h0, 1'b1,
                (offs[k] == 6'h18) ? 32'd1000 : (offs[k] == 6'h24) ? 32'h10 : 32'h0,
                $sformatf("reset_ch%0d_off%02h", c, offs[k]));
         end
      end
      add(1'b1, 32'h200, 32'h55, 1'b0, 0, "");
      add(1'b0, 32'h000, 0, 1'b1, 32'h0,    "hi_addr_write_ignored");
      add(1'b1, 32'h018, 32'h5, 1'b0, 0, "");
      add(1'b0, 32'h018, 0, 1'b1, 32'd1000, "delta_time_ro");
      add(1'b0, 32'h028, 0, 1'b1, 32'h0,    "unmapped_offset");
      add(1'b1, 32'h080, 32'h77, 1'b0, 0, "");
      add(1'b0, 32'h080, 0, 1'b1, 32'h0,    "channel2_absent");
      add(1'b1, 32'h040, 32'd16, 1'b0, 0, "");
      add(1'b1, 32'h044, 32'd64, 1'b0, 0, "");
      add(1'b0, 32'h040, 0, 1'b1, 32'd16,   "ch1_slice_rb");
      add(1'b0, 32'h044, 0, 1'b1, 32'd64,   "ch1_frame_rb");

      bus.wbs_stb_i = 0; bus.wbs_we_i = 0; bus.wbs_addr_i = 0; bus.wbs_data_i = 0;
      bus.timer_valid_i = 1'b0; bus.timer_i = 64'd0; bus.cmd_ready_i = 2'b00;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_ack",   CMD_W'(bus.wbs_ack_o),   0);
      chk("reset_rdata", CMD_W'(bus.wbs_data_o),  0);
      chk("reset_valid", CMD_W'(bus.cmd_valid_o), 0);
      chk("reset_data",  CMD_W'(bus.cmd_data_o),  0);
      arst_n = 1'b1;
      @(posedge clk); #1;

      // ack must rise on the first edge after strobe
      bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0; bus.wbs_addr_i = 32'h18;
      @(posedge clk); #1;
      chk("ack_latency", CMD_W'(bus.wbs_ack_o), 1);
      chk("first_read",  CMD_W'(bus.wbs_data_o), 1000);
      bus.wbs_stb_i = 1'b0;
      @(posedge clk); #1;
      chk("ack_one_cycle", CMD_W'(bus.wbs_ack_o), 0);

      foreach (vq[i]) begin
         access(vq[i].we, vq[i].addr, vq[i].data, rd);
         if (vq[i].chk) chk(vq[i].name, CMD_W'(rd), CMD_W'(vq[i].exp));
      end

      // START on ch1 with default delta, head holds until ready
      bus.timer_valid_i = 1'b1; bus.timer_i = 64'd5000;
      wr(32'h060, 32'h01);
      chk("start_valid", CMD_W'(bus.cmd_valid_o), CMD_W'(2'b10));
      chk("start_head",  head(1), mk(64, 16, 64'd6000, 8'h01));
      bus.timer_i = 64'd9999;
      repeat (3) @(posedge clk);
      #1;
      chk("start_hold", head(1), mk(64, 16, 64'd6000, 8'h01));
      bus.cmd_ready_i = 2'b10;
      @(posedge clk); #1;
      bus.cmd_ready_i = 2'b00;
      chk("start_popped", CMD_W'(bus.cmd_valid_o), 0);

      // STOP with user delta across the timestamp wrap
      wr(32'h01C, 32'h20);
      bus.timer_i = 64'hFFFF_FFFF_FFFF_FFF0;
      wr(32'h020, 32'h02);
      chk("wrap_head", head(0), mk(0, 0, 64'h10, 8'h02));
      bus.cmd_ready_i = 2'b01;
      @(posedge clk); #1;
      bus.cmd_ready_i = 2'b00;
      chk("wrap_popped", CMD_W'(bus.cmd_valid_o), 0);

      // overflow on ch0, then ABORT, then sticky clear
      bus.timer_i = 64'd100;
      for (int i = 0; i < 5; i++) wr(32'h020, 32'h01);
      rd_chk("ovf_status", 32'h024, 32'h0409);
      wr(32'h020, 32'h08);
      rd_chk("abort_status", 32'h024, 32'h0101);
      chk("abort_head", head(0), mk(0, 0, 64'd0, 8'h08));
      wr(32'h024, 32'h1);
      rd_chk("ovf_cleared", 32'h024, 32'h0100);
      bus.cmd_ready_i = 2'b01;
      @(posedge clk); #1;
      bus.cmd_ready_i = 2'b00;
      rd_chk("abort_drained", 32'h024, 32'h0010);

      // illegal opcode
      wr(32'h020, 32'h03);
      rd_chk("bad_code", 32'h024, 32'h0012);
      wr(32'h024, 32'h7);

      // timer loss flushes the FIFO and rejects CONTROL writes
      wr(32'h020, 32'h02);
      chk("tv_queued", CMD_W'(bus.cmd_valid_o[0]), 1);
      bus.timer_valid_i = 1'b0;
      @(posedge clk); #1;
      chk("tv_flushed", CMD_W'(bus.cmd_valid_o), 0);
      wr(32'h020, 32'h01);
      rd_chk("rejected", 32'h024, 32'h0014);
      rd_chk("tv_cfg_kept", 32'h01C, 32'h20);
      chk("tv_still_empty", CMD_W'(bus.cmd_valid_o), 0);
      bus.timer_valid_i = 1'b1;
      wr(32'h024, 32'h7);

      // full FIFO with a pop on the push edge
      for (int i = 1; i <= 4; i++) begin
         bus.timer_i = 64'(i);
         wr(32'h020, 32'h02);
      end
      @(posedge clk); #1;
      bus.timer_i = 64'd5;
      bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1; bus.wbs_addr_i = 32'h020; bus.wbs_data_i = 32'h04;
      bus.cmd_ready_i = 2'b01;
      @(posedge clk); #1;
      bus.wbs_stb_i = 1'b0;
      bus.cmd_ready_i = 2'b00;
      chk("fullpop_ack", CMD_W'(bus.wbs_ack_o), 1);
      rd_chk("fullpop_status", 32'h024, 32'h0408);
      bus.cmd_ready_i = 2'b01;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("drain_%0d", i), head(0),
             mk(0, 0, 64'(34 + i), (i == 3) ? 8'h04 : 8'h02));
         @(posedge clk); #1;
      end
      bus.cmd_ready_i = 2'b00;
      chk("drain_empty", CMD_W'(bus.cmd_valid_o), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
